// File: rtl/io_controller.sv
// io_controller: memory-mapped board I/O block for a small CPU.
//   Registers (addr): 0 HEX value, 1 LEDR, 2 LEDG, 3 SW (ro), 4 KEY level (ro),
//   5 KEY pending (read, write-1-to-clear), 6 HEX blank mask, 7 IRQ mask.
// Ports:
//   clk, reset (async, active-low)
//   wrEn/rdEn/addr/dataIn : CPU register access; ioOut : registered read data
//   switches, keys        : raw asynchronous board pins (keys active-low)
//   hex                   : 7 segments per digit, active-low, bit 6 = g
//   ledr, ledg            : LED outputs
//   irq                   : level interrupt, OR of enabled pending key presses
module io_controller #(
    parameter int DATA_BIT_WIDTH = 32,
    parameter int NUM_HEX        = 4,
    parameter int NUM_LEDR       = 10,
    parameter int NUM_LEDG       = 8,
    parameter int NUM_SW         = 10,
    parameter int NUM_KEYS       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wrEn,
    input  logic                      rdEn,
    input  logic [2:0]                addr,
    input  logic [DATA_BIT_WIDTH-1:0] dataIn,
    output logic [DATA_BIT_WIDTH-1:0] ioOut,
    input  logic [NUM_SW-1:0]         switches,
    input  logic [NUM_KEYS-1:0]       keys,
    output logic [7*NUM_HEX-1:0]      hex,
    output logic [NUM_LEDR-1:0]       ledr,
    output logic [NUM_LEDG-1:0]       ledg,
    output logic                      irq
);

    localparam int HEX_W = 4 * NUM_HEX;

    localparam logic [2:0] ADDR_HEX   = 3'd0;
    localparam logic [2:0] ADDR_LEDR  = 3'd1;
    localparam logic [2:0] ADDR_LEDG  = 3'd2;
    localparam logic [2:0] ADDR_SW    = 3'd3;
    localparam logic [2:0] ADDR_KEY   = 3'd4;
    localparam logic [2:0] ADDR_PEND  = 3'd5;
    localparam logic [2:0] ADDR_BLANK = 3'd6;
    localparam logic [2:0] ADDR_MASK  = 3'd7;

    // Hex nibble to active-low seven-segment pattern (bit 6 = g ... bit 0 = a).
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [NUM_SW-1:0]         sw_meta_r, sw_sync_r;
    logic [NUM_KEYS-1:0]       key_meta_r, key_sync_r, key_prev_r;
    logic [HEX_W-1:0]          hex_val_r, hex_val_next_s;
    logic [NUM_HEX-1:0]        blank_r, blank_next_s;
    logic [7*NUM_HEX-1:0]      hex_r, hex_next_s;
    logic [NUM_LEDR-1:0]       ledr_r;
    logic [NUM_LEDG-1:0]       ledg_r;
    logic [NUM_KEYS-1:0]       pend_r, pend_next_s, press_s, clr_s, irq_mask_r;
    logic                      irq_r;
    logic [DATA_BIT_WIDTH-1:0] io_out_r, rd_data_s;
    logic                      unused_data_s;

    // Upper write-data bits beyond the widest register are intentionally ignored.
    assign unused_data_s = ^dataIn;

    // Next-state of the display registers and the key-pending set/clear logic.
    always_comb begin
        hex_val_next_s = hex_val_r;
        blank_next_s   = blank_r;
        clr_s          = {NUM_KEYS{1'b0}};
        if (wrEn && (addr == ADDR_HEX)) begin
            hex_val_next_s = dataIn[HEX_W-1:0];
        end else begin
            hex_val_next_s = hex_val_r;
        end
        if (wrEn && (addr == ADDR_BLANK)) begin
            blank_next_s = dataIn[NUM_HEX-1:0];
        end else begin
            blank_next_s = blank_r;
        end
        if (wrEn && (addr == ADDR_PEND)) begin
            clr_s = dataIn[NUM_KEYS-1:0];
        end else begin
            clr_s = {NUM_KEYS{1'b0}};
        end
        // Press edge: key now low, was high one sample earlier. Set beats clear.
        press_s     = ~key_sync_r & key_prev_r;
        pend_next_s = (pend_r & ~clr_s) | press_s;
    end

    // Segment patterns computed from next-state so hex tracks the registers with no extra lag.
    always_comb begin
        hex_next_s = {(7*NUM_HEX){1'b1}};
        for (int i = 0; i < NUM_HEX; i++) begin
            if (blank_next_s[i]) begin
                hex_next_s[7*i +: 7] = 7'h7F;
            end else begin
                hex_next_s[7*i +: 7] = seg_decode(hex_val_next_s[4*i +: 4]);
            end
        end
    end

    // Read multiplexer, zero-extended; reflects pre-write state on same-cycle write.
    always_comb begin
        rd_data_s = {DATA_BIT_WIDTH{1'b0}};
        case (addr)
            ADDR_HEX:   rd_data_s[HEX_W-1:0]    = hex_val_r;
            ADDR_LEDR:  rd_data_s[NUM_LEDR-1:0] = ledr_r;
            ADDR_LEDG:  rd_data_s[NUM_LEDG-1:0] = ledg_r;
            ADDR_SW:    rd_data_s[NUM_SW-1:0]   = sw_sync_r;
            ADDR_KEY:   rd_data_s[NUM_KEYS-1:0] = key_sync_r;
            ADDR_PEND:  rd_data_s[NUM_KEYS-1:0] = pend_r;
            ADDR_BLANK: rd_data_s[NUM_HEX-1:0]  = blank_r;
            ADDR_MASK:  rd_data_s[NUM_KEYS-1:0] = irq_mask_r;
            default:    rd_data_s               = {DATA_BIT_WIDTH{1'b0}};
        endcase
    end

    // Two-flop synchronizers plus previous-key flop; all ones so released keys never look pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r  <= {NUM_SW{1'b1}};
            sw_sync_r  <= {NUM_SW{1'b1}};
            key_meta_r <= {NUM_KEYS{1'b1}};
            key_sync_r <= {NUM_KEYS{1'b1}};
            key_prev_r <= {NUM_KEYS{1'b1}};
        end else begin
            sw_meta_r  <= switches;
            sw_sync_r  <= sw_meta_r;
            key_meta_r <= keys;
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
        end
    end

    // CPU-writable registers, pending flags and the registered hex pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_val_r  <= {HEX_W{1'b0}};
            blank_r    <= {NUM_HEX{1'b1}};
            hex_r      <= {(7*NUM_HEX){1'b1}};
            ledr_r     <= {NUM_LEDR{1'b0}};
            ledg_r     <= {NUM_LEDG{1'b0}};
            irq_mask_r <= {NUM_KEYS{1'b0}};
            pend_r     <= {NUM_KEYS{1'b0}};
        end else begin
            hex_val_r <= hex_val_next_s;
            blank_r   <= blank_next_s;
            hex_r     <= hex_next_s;
            pend_r    <= pend_next_s;
            if (wrEn && (addr == ADDR_LEDR)) begin
                ledr_r <= dataIn[NUM_LEDR-1:0];
            end else begin
                ledr_r <= ledr_r;
            end
            if (wrEn && (addr == ADDR_LEDG)) begin
                ledg_r <= dataIn[NUM_LEDG-1:0];
            end else begin
                ledg_r <= ledg_r;
            end
            if (wrEn && (addr == ADDR_MASK)) begin
                irq_mask_r <= dataIn[NUM_KEYS-1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
        end
    end

    // Registered read data and interrupt request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_out_r <= {DATA_BIT_WIDTH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            if (rdEn) begin
                io_out_r <= rd_data_s;
            end else begin
                io_out_r <= io_out_r;
            end
            irq_r <= |(pend_r & irq_mask_r);
        end
    end

    assign ioOut = io_out_r;
    assign hex   = hex_r;
    assign ledr  = ledr_r;
    assign ledg  = ledg_r;
    assign irq   = irq_r;

endmodule
